// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl
//   Iterative signed two's-complement multiplier. A single (WIDTH+1)-bit
//   adder is reused for WIDTH cycles to build a 2*WIDTH-bit product.
//   Operands come in over a valid/ready channel. The product leaves over a
//   second valid/ready channel.
//
// Ports
//   CLK_i       clock, rising edge
//   RSTn_i      asynchronous active-low reset
//   CLR_i       synchronous abort: back to IDLE, operation discarded
//   DIN_VLD_i   operand pair valid
//   DIN_RDY_o   controller can accept operands (IDLE only)
//   DIN1_i      multiplicand A, signed
//   DIN2_i      multiplier B, signed
//   DOUT_VLD_o  product valid (DONE)
//   DOUT_RDY_i  consumer accepts product
//   DOUT_o      signed product A*B, held until the next product completes
//   BUSY_o      high while iterating
//
// WIDTH must be at least 3. The low-product shift register is WIDTH-1 bits
// wide, and its shift uses the slice [WIDTH-2:1].
// ---------------------------------------------------------------------------
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 CLK_i,
  input  logic                 RSTn_i,
  input  logic                 CLR_i,
  input  logic                 DIN_VLD_i,
  output logic                 DIN_RDY_o,
  input  logic [WIDTH-1:0]     DIN1_i,
  input  logic [WIDTH-1:0]     DIN2_i,
  output logic                 DOUT_VLD_o,
  input  logic                 DOUT_RDY_i,
  output logic [2*WIDTH-1:0]   DOUT_o,
  output logic                 BUSY_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic               w_accept;
  logic               w_step_en;
  logic               w_last;
  logic               w_bit;
  logic               w_cin;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;       // shifted right each step; bit 0 is B[k]
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-2:0]   r_lo;      // low product bits, filled from the top
  logic [CW-1:0]      r_step;
  logic [2*WIDTH-1:0] r_dout;

  // State register
  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_next     = r_state;
    DIN_RDY_o  = 1'b0;
    DOUT_VLD_o = 1'b0;
    BUSY_o     = 1'b0;
    w_accept   = 1'b0;
    w_step_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        DIN_RDY_o = 1'b1;
        if (DIN_VLD_i) begin
          w_accept = 1'b1;
          w_next   = S_BUSY;
        end
      end
      S_BUSY: begin
        BUSY_o    = 1'b1;
        w_step_en = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        DOUT_VLD_o = 1'b1;
        if (DOUT_RDY_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort overrides every transition, including a same-cycle accept.
    if (CLR_i) begin
      w_next    = S_IDLE;
      w_accept  = 1'b0;
      w_step_en = 1'b0;
    end
  end

  // Shared adder. The last step subtracts the sign-weighted partial
  // product (B's MSB has weight -2^(WIDTH-1)). The subtraction is done
  // as inversion plus a carry-in of 1.
  assign w_last   = (r_step == LAST_STEP);
  assign w_bit    = r_b[0];
  assign w_addend = !w_bit ? '0 :
                    w_last ? ~{r_a[WIDTH-1], r_a} : {r_a[WIDTH-1], r_a};
  assign w_cin    = w_last & w_bit;
  assign w_sum    = r_acc + w_addend + {{WIDTH{1'b0}}, w_cin};

  // Datapath registers
  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_lo   <= '0;
      r_step <= '0;
      r_dout <= '0;
    end else if (w_accept) begin
      r_a    <= DIN1_i;
      r_b    <= DIN2_i;
      r_acc  <= '0;
      r_lo   <= '0;
      r_step <= '0;
    end else if (w_step_en) begin
      r_b <= r_b >> 1;
      if (w_last) begin
        r_step <= '0;
        r_dout <= {w_sum, r_lo};
      end else begin
        r_step <= r_step + CW'(1);
        r_acc  <= {w_sum[WIDTH], w_sum[WIDTH:1]};
        r_lo   <= {w_sum[0], r_lo[WIDTH-2:1]};
      end
    end
  end

  assign DOUT_o = r_dout;

endmodule
